_decode_issue: RTL and testbench

Decode/issue stage directly upstream of the 8-entry register file. Accepts 16-bit instruction words over a valid/ready handshake and holds one in an ID register. It drives the register file's read addresses, write-address mux, immediate bus and write strobes, and tracks outstanding writes in an 8-bit scoreboard. It issues into a single-entry ID/EX output register toward execute and stalls on data hazards, port conflicts and downstream backpressure.

---
 rtl/_decode_issue_if.sv | 30 +++
 rtl/_decode_issue.sv | 88 ++++++++
 tb/tb__decode_issue.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/_decode_issue_if.sv
// Fetch, register-file, writeback and execute signals of the decode/issue stage.
// master drives the stage from outside; slave is the stage itself.
interface _decode_issue_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  A1;
  logic [2:0]  A2;
  logic [2:0]  A3;
  logic        WE3;
  logic        Rwe2;
  logic [7:0]  i2;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [2:0]  ex_rd;
  logic        ex_ready;
  logic        halted;

  modport master (
    output instr_valid, instr, wb_valid, wb_addr, ex_ready,
    input  instr_ready, A1, A2, A3, WE3, Rwe2, i2, ex_valid, ex_op, ex_rd, halted
  );

  modport slave (
    input  instr_valid, instr, wb_valid, wb_addr, ex_ready,
    output instr_ready, A1, A2, A3, WE3, Rwe2, i2, ex_valid, ex_op, ex_rd, halted
  );
endinterface

// File: rtl/_decode_issue.sv
// Decode/issue stage: one ID register, 8-bit write scoreboard, single-entry ID/EX register.
// LI writes the register file directly on its issue edge; ALU ops go to execute.
module _decode_issue (
  input  logic           clk,
  input  logic           rst,
  _decode_issue_if.slave bus
);
  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  logic [0:0]  state_q;
  logic        id_valid_q;
  logic [15:0] id_instr_q;
  logic        ex_valid_q;
  logic [3:0]  ex_op_q;
  logic [2:0]  ex_rd_q;
  logic [7:0]  pending_q, pending_d;

  logic [3:0] op;
  logic [2:0] rd, rs1, rs2;
  logic       is_li, is_halt, is_alu;
  logic       stall, issue, accept;

  always_comb begin
    op      = id_instr_q[15:12];
    rd      = id_instr_q[11:9];
    rs1     = id_instr_q[8:6];
    rs2     = id_instr_q[5:3];
    is_li   = (op == 4'h1);
    is_halt = (op == 4'hF);
    is_alu  = (op != 4'h0) && !is_li && !is_halt;
    // rs2 == 0 selects the immediate, so it never waits on the scoreboard
    stall   = (is_alu && pending_q[rs1])
            || (is_alu && (rs2 != 3'd0) && pending_q[rs2])
            || ((is_alu || is_li) && pending_q[rd])
            || (is_li && bus.wb_valid)
            || (is_alu && ex_valid_q && !bus.ex_ready);
    issue   = id_valid_q && !stall && (state_q == StRun);
    accept  = bus.instr_valid && bus.instr_ready;
  end

  always_comb begin
    pending_d = pending_q;
    if (bus.wb_valid) pending_d[bus.wb_addr] = 1'b0;
    // A same-cycle set beats the writeback clear
    if (issue && is_alu) pending_d[rd] = 1'b1;
  end

  assign bus.instr_ready = (state_q == StRun) && (!id_valid_q || issue);
  assign bus.halted      = (state_q == StHalt);
  assign bus.A1          = rs1;
  assign bus.A2          = rs2;
  assign bus.A3          = bus.wb_valid ? bus.wb_addr : rd;
  assign bus.WE3         = bus.wb_valid;
  assign bus.Rwe2        = issue && is_li;
  assign bus.i2          = is_li ? id_instr_q[7:0] : {5'b0, id_instr_q[2:0]};
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_op       = ex_op_q;
  assign bus.ex_rd       = ex_rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      id_valid_q <= 1'b0;
      id_instr_q <= 16'h0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= 4'h0;
      ex_rd_q    <= 3'd0;
      pending_q  <= 8'h0;
    end else begin
      pending_q <= pending_d;
      if (issue && is_halt) state_q <= StHalt;
      if (accept) begin
        id_valid_q <= 1'b1;
        id_instr_q <= bus.instr;
      end else if (issue) begin
        id_valid_q <= 1'b0;
      end
      if (issue && is_alu) begin
        ex_valid_q <= 1'b1;
        ex_op_q    <= op;
        ex_rd_q    <= rd;
      end else if (bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb__decode_issue.sv
// Directed vector table for the decode/issue stage, then randomized traffic against
// a behavioural model of the issue rules.
module tb__decode_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  _decode_issue_if bus ();

  _decode_issue dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] ins;
    logic        wbv;
    logic [2:0]  wba;
    logic        exr;
    logic        rdy;
    logic        rwe2;
    logic [2:0]  a3;
    logic [7:0]  i2;
    logic        exv;
    logic [3:0]  exop;
    logic [2:0]  exrd;
    logic        hlt;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // model state
  bit          m_idv, m_exv, m_halt;
  logic [15:0] m_idw;
  logic [3:0]  m_exop;
  logic [2:0]  m_exrd;
  bit          m_pend[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [15:0] ins, input logic wbv,
                     input logic [2:0] wba, input logic exr, input logic rdy,
                     input logic rwe2, input logic [2:0] a3, input logic [7:0] i2,
                     input logic exv, input logic [3:0] exop, input logic [2:0] exrd,
                     input logic hlt);
    vq.push_back('{iv, ins, wbv, wba, exr, rdy, rwe2, a3, i2, exv, exop, exrd, hlt});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " instr_ready"}, bus.instr_ready, 1);
    chk({tag, " halted"}, bus.halted, 0);
    chk({tag, " ex_valid"}, bus.ex_valid, 0);
    chk({tag, " ex_op"}, bus.ex_op, 0);
    chk({tag, " ex_rd"}, bus.ex_rd, 0);
    chk({tag, " Rwe2"}, bus.Rwe2, 0);
    chk({tag, " A3"}, bus.A3, 0);
    chk({tag, " i2"}, bus.i2, 0);
  endtask

  task automatic model_reset();
    m_idv = 0; m_exv = 0; m_halt = 0; m_idw = 0; m_exop = 0; m_exrd = 0;
    foreach (m_pend[k]) m_pend[k] = 0;
  endtask

  task automatic drive(input logic iv, input logic [15:0] ins, input logic wbv,
                       input logic [2:0] wba, input logic exr);
    bus.instr_valid = iv; bus.instr = ins; bus.wb_valid = wbv;
    bus.wb_addr = wba; bus.ex_ready = exr;
  endtask

  initial begin
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    bit         stall, iss, e_rdy, is_li, is_alu;
    int         r;
    logic [15:0] w;

    drive(0, 16'h0, 0, 3'd0, 1);

    // iv ins wbv wba exr | rdy rwe2 a3 i2 exv exop exrd hlt
    add(1, 16'h165A, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);  // accept LI r3,5A
    add(1, 16'h1801, 0, 0, 1, 1, 1, 3, 8'h5A, 0, 0, 0, 0);  // LI r3 issues
    add(1, 16'h24E0, 0, 0, 1, 1, 1, 4, 8'h01, 0, 0, 0, 0);  // LI r4 back-to-back
    add(1, 16'h3A86, 0, 0, 1, 1, 0, 2, 8'h00, 0, 0, 0, 0);  // ALU r2,r3,r4 issues
    add(0, 16'h0000, 0, 0, 1, 0, 0, 5, 8'h06, 1, 2, 2, 0);  // r5 waits on r2
    add(0, 16'h0000, 1, 2, 1, 0, 0, 2, 8'h06, 0, 2, 2, 0);  // wb r2: still stalls
    add(0, 16'h0000, 0, 0, 1, 1, 0, 5, 8'h06, 0, 2, 2, 0);  // issues next cycle
    add(1, 16'h1210, 0, 0, 0, 1, 0, 5, 8'h06, 1, 3, 5, 0);  // accept LI r1,10
    add(0, 16'h0000, 1, 6, 0, 0, 0, 6, 8'h10, 1, 3, 5, 0);  // A3 port conflict
    add(1, 16'h4C01, 0, 0, 0, 1, 1, 1, 8'h10, 1, 3, 5, 0);  // LI r1 issues
    for (int k = 0; k < 3; k++)
      add(0, 16'h0000, 0, 0, 0, 0, 0, 6, 8'h01, 1, 3, 5, 0);  // execute backpressure
    add(1, 16'h5E00, 0, 0, 1, 1, 0, 6, 8'h01, 1, 3, 5, 0);  // replace with no bubble
    add(1, 16'h61C0, 1, 7, 1, 1, 0, 7, 8'h00, 1, 4, 6, 0);  // r7 set vs wb clear
    add(0, 16'h0000, 0, 0, 1, 0, 0, 0, 8'h00, 1, 5, 7, 0);  // r7 still pending
    add(0, 16'h0000, 1, 7, 1, 0, 0, 7, 8'h00, 0, 5, 7, 0);
    add(1, 16'hF000, 0, 0, 1, 1, 0, 0, 8'h00, 0, 5, 7, 0);  // reader issues
    add(1, 16'h1210, 0, 0, 1, 1, 0, 0, 8'h00, 1, 6, 0, 0);  // HALT issues
    for (int k = 0; k < 10; k++)
      add(1, 16'h1210, 0, 0, 1, 0, 0, 1, 8'h10, 0, 6, 0, 1);  // halted

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 1'b0;

    foreach (vq[k]) begin
      drive(vq[k].iv, vq[k].ins, vq[k].wbv, vq[k].wba, vq[k].exr);
      @(negedge clk);
      chk($sformatf("v%0d instr_ready", k), bus.instr_ready, vq[k].rdy);
      chk($sformatf("v%0d Rwe2", k), bus.Rwe2, vq[k].rwe2);
      chk($sformatf("v%0d A3", k), bus.A3, vq[k].a3);
      chk($sformatf("v%0d WE3", k), bus.WE3, vq[k].wbv);
      chk($sformatf("v%0d i2", k), bus.i2, vq[k].i2);
      chk($sformatf("v%0d ex_valid", k), bus.ex_valid, vq[k].exv);
      chk($sformatf("v%0d ex_op", k), bus.ex_op, vq[k].exop);
      chk($sformatf("v%0d ex_rd", k), bus.ex_rd, vq[k].exrd);
      chk($sformatf("v%0d halted", k), bus.halted, vq[k].hlt);
      @(posedge clk);
      #1;
    end

    // Reset while halted with r5 still pending: LI r5 must then issue without stalling
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 16'h1A33, 0, 3'd0, 1);
    @(negedge clk);
    chk("post-rst instr_ready", bus.instr_ready, 1);
    @(posedge clk);
    #1;
    drive(0, 16'h0, 0, 3'd0, 1);
    @(negedge clk);
    chk("post-rst Rwe2", bus.Rwe2, 1);
    chk("post-rst A3", bus.A3, 5);
    chk("post-rst i2", bus.i2, 8'h33);
    @(posedge clk);
    #1;

    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        #1;
        chk("rnd rst instr_ready", bus.instr_ready, 1);
        chk("rnd rst ex_valid", bus.ex_valid, 0);
        rst = 1'b0;
        model_reset();
      end
      r = $urandom_range(0, 99);
      w = 16'($urandom);
      if (r < 5)       op = 4'h0;
      else if (r < 35) op = 4'h1;
      else if (r < 37) op = 4'hF;
      else             op = 4'($urandom_range(2, 14));
      w[15:12] = op;
      w[11:9]  = 3'($urandom_range(0, 3));
      if (op != 4'h1) begin
        w[8:6] = 3'($urandom_range(0, 3));
        w[5:3] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 3));
      end
      drive($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) == 0,
            3'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      @(negedge clk);

      op  = m_idw[15:12];
      rd  = m_idw[11:9];
      rs1 = m_idw[8:6];
      rs2 = m_idw[5:3];
      is_li  = (op == 1);
      is_alu = (op >= 2) && (op <= 14);
      if (is_li)       stall = m_pend[rd] || bus.wb_valid;
      else if (is_alu) stall = m_pend[rs1] || (rs2 != 0 && m_pend[rs2]) || m_pend[rd]
                               || (m_exv && !bus.ex_ready);
      else             stall = 0;
      iss   = m_idv && !stall && !m_halt;
      e_rdy = !m_halt && (!m_idv || iss);

      chk("rnd instr_ready", bus.instr_ready, e_rdy);
      chk("rnd halted", bus.halted, m_halt);
      chk("rnd A1", bus.A1, rs1);
      chk("rnd A2", bus.A2, rs2);
      chk("rnd A3", bus.A3, bus.wb_valid ? bus.wb_addr : rd);
      chk("rnd WE3", bus.WE3, bus.wb_valid);
      chk("rnd Rwe2", bus.Rwe2, iss && is_li);
      chk("rnd i2", bus.i2, is_li ? m_idw[7:0] : {5'b0, m_idw[2:0]});
      chk("rnd ex_valid", bus.ex_valid, m_exv);
      chk("rnd ex_op", bus.ex_op, m_exop);
      chk("rnd ex_rd", bus.ex_rd, m_exrd);

      if (bus.wb_valid) m_pend[bus.wb_addr] = 0;
      if (iss && is_alu) begin
        m_pend[rd] = 1;
        m_exv = 1; m_exop = op; m_exrd = rd;
      end else if (bus.ex_ready) begin
        m_exv = 0;
      end
      if (iss && op == 15) m_halt = 1;
      if (bus.instr_valid && e_rdy) begin
        m_idv = 1; m_idw = bus.instr;
      end else if (iss) begin
        m_idv = 0;
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
